// File: rtl/count_sched_pkg.sv
// Shared constants, state encoding and overflow helper for the count scheduler.
package count_sched_pkg;

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned STEP_W = 4;
    localparam int unsigned NDIG   = 3;
    localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2,
        StHold  = 2'd3
    } state_e;

    // True when applying stp in direction up would leave the 0..255 range.
    // Landing exactly on 0 or 255 is not an overflow.
    function automatic logic step_overflows(input logic              up,
                                            input logic [CNT_W-1:0]  cnt,
                                            input logic [STEP_W-1:0] stp);
        logic [CNT_W:0]   sum;
        logic [CNT_W-1:0] stp_ext;
        stp_ext = {{(CNT_W - STEP_W){1'b0}}, stp};
        sum     = {1'b0, cnt} + {1'b0, stp_ext};
        return up ? sum[CNT_W] : (stp_ext > cnt);
    endfunction

endpackage

// File: rtl/pulse_div.sv
// Modulo-DIV cycle divider; tick is high during the last cycle of each period.
module pulse_div #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == LAST);

    // Next count: clear dominates, otherwise advance and wrap while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + W'(1);
        end
    end

    // Divider state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/count_sched.sv
// Run/pause/saturation controller and digit-scan scheduler for the counter display.
module count_sched
    import count_sched_pkg::*;
#(
    parameter int unsigned TICK_DIV = 4,
    parameter int unsigned SCAN_DIV = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pause,
    input  logic              clear,
    input  logic              sat_mode,
    input  logic              up_down,
    input  logic [STEP_W-1:0] step,
    input  logic [CNT_W-1:0]  count,
    output logic              cnt_en,
    output logic              cnt_up,
    output logic [STEP_W-1:0] cnt_step,
    output logic              cnt_load,
    output logic [CNT_W-1:0]  cnt_load_val,
    output logic [1:0]        seg_sel,
    output logic [1:0]        state
);

    state_e              state_q, state_d;
    logic                cnt_en_q, cnt_en_d;
    logic                cnt_load_q, cnt_load_d;
    logic [CNT_W-1:0]    load_val_q, load_val_d;
    logic                cnt_up_q, cnt_up_d;
    logic [STEP_W-1:0]   cnt_step_q, cnt_step_d;
    logic [1:0]          seg_sel_q, seg_sel_d;

    logic run;
    logic tick;
    logic scan_tick;
    logic ovf;

    assign run = (state_q == StRun);

    // Prescaler only runs in RUN and is held at zero elsewhere, so every
    // entry to RUN starts a fresh full period.
    pulse_div #(
        .DIV (TICK_DIV)
    ) u_presc (
        .clk  (clk),
        .rst  (rst),
        .clr  (!run),
        .en   (run),
        .tick (tick)
    );

    pulse_div #(
        .DIV (SCAN_DIV)
    ) u_scan (
        .clk  (clk),
        .rst  (rst),
        .clr  (1'b0),
        .en   (1'b1),
        .tick (scan_tick)
    );

    // Evaluated against the live step/direction, which are what get latched on a tick.
    assign ovf = step_overflows(up_down, count, step);

    // FSM next state and registered pulse/step/direction outputs.
    always_comb begin
        state_d    = state_q;
        cnt_en_d   = 1'b0;
        cnt_load_d = 1'b0;
        load_val_d = load_val_q;
        cnt_up_d   = cnt_up_q;
        cnt_step_d = cnt_step_q;
        if (clear) begin
            state_d    = StIdle;
            cnt_load_d = 1'b1;
            load_val_d = '0;
        end else begin
            case (state_q)
                StIdle, StPause: begin
                    if (start) state_d = StRun;
                end
                StRun: begin
                    if (pause) begin
                        state_d = StPause;
                    end else if (tick) begin
                        cnt_step_d = step;
                        cnt_up_d   = up_down;
                        if (sat_mode && ovf) begin
                            cnt_load_d = 1'b1;
                            load_val_d = up_down ? CNT_MAX : '0;
                            state_d    = StHold;
                        end else begin
                            cnt_en_d = 1'b1;
                        end
                    end
                end
                StHold: begin
                    // cnt_up_q still holds the direction latched at saturation.
                    if (up_down != cnt_up_q) state_d = StRun;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Digit select walks 0..NDIG-1 on each scan divider wrap.
    always_comb begin
        seg_sel_d = seg_sel_q;
        if (scan_tick) begin
            seg_sel_d = (seg_sel_q == 2'(NDIG - 1)) ? 2'd0 : seg_sel_q + 2'd1;
        end
    end

    // All scheduler state and outputs, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_en_q   <= 1'b0;
            cnt_load_q <= 1'b0;
            load_val_q <= '0;
            cnt_up_q   <= 1'b1;
            cnt_step_q <= '0;
            seg_sel_q  <= 2'd0;
        end else begin
            state_q    <= state_d;
            cnt_en_q   <= cnt_en_d;
            cnt_load_q <= cnt_load_d;
            load_val_q <= load_val_d;
            cnt_up_q   <= cnt_up_d;
            cnt_step_q <= cnt_step_d;
            seg_sel_q  <= seg_sel_d;
        end
    end

    assign cnt_en       = cnt_en_q;
    assign cnt_load     = cnt_load_q;
    assign cnt_load_val = load_val_q;
    assign cnt_up       = cnt_up_q;
    assign cnt_step     = cnt_step_q;
    assign seg_sel      = seg_sel_q;
    assign state        = state_q;

endmodule

// File: doc/count_sched.md
# count_sched

Run/pause/saturation controller and digit-scan scheduler for the 8-bit variable-step counter display. It sits between the board switches and the counter/display datapath. It issues timed count-enable pulses with glitch-free step and direction updates, detects overflow and forces a clamp load in saturating mode, and drives the 3-digit select for the BCD display mux.

## Interface
- `TICK_DIV`, 4: clocks per count tick; must be ≥2.
- `SCAN_DIV`, 2: clocks per digit-select advance; must be ≥1.
- `clk` in 1: the only clock.
- `rst` in 1: one clock; reset is synchronous and active-high.
- `start` in 1: level sampled each clock. Moves IDLE or PAUSE to RUN. Ignored in RUN and HOLD.
- `pause` in 1: moves RUN to PAUSE. Ignored elsewhere.
- `clear` in 1: from any state, loads 0 and goes to IDLE. Highest priority.
- `sat_mode` in 1: 1 means saturate at 0/255; 0 means wrap modulo 256.
- `up_down` in 1: 1 means up, 0 means down.
- `step` in 4: step size, 0–15.
- `count` in 8: current counter value, fed back from the counter.
- `cnt_en` out 1: one-cycle pulse; the counter applies `cnt_step` in direction `cnt_up`.
- `cnt_up` out 1: latched direction.
- `cnt_step` out 4: latched step.
- `cnt_load` out 1: one-cycle pulse; the counter loads `cnt_load_val`.
- `cnt_load_val` out 8: load value.
- `seg_sel` out 2: digit select, cycling 0, 1, 2.
- `state` out 2: IDLE=0, RUN=1, PAUSE=2, HOLD=3.

## Operation
- **FSM**
  - IDLE: `start` goes to RUN.
  - RUN: `pause` goes to PAUSE. Each tick evaluates the next step.
  - PAUSE: `start` goes to RUN.
  - HOLD: entered on saturation. When `up_down` ≠ the direction latched at saturation, go to RUN.
  - All states: `clear` forces a load of 0, then IDLE.
- **Prescaler**
  - Counts 0..TICK_DIV-1 only in RUN. Forced to 0 in every other state and on every entry to RUN.
  - A tick occurs in the cycle where the prescaler equals TICK_DIV-1.
- **Tick cycle (RUN, no `clear`/`pause`)**
  - Sample `step` and `up_down` into `cnt_step`/`cnt_up`. These outputs change only here, so they are stable between pulses.
  - Evaluate overflow on `count` with the sampled values using a 9-bit sum:
    - up: `count` + `step` > 255
    - down: `step` > `count`
  - If `sat_mode`=1 and overflow: next cycle `cnt_load`=1, `cnt_load_val`=255 (up) or 0 (down), no `cnt_en`, state goes to HOLD.
  - Otherwise: next cycle `cnt_en`=1.
  - Step 0 still pulses `cnt_en` (count unchanged).
  - Exact reach (e.g. 250+5=255, or 5−5=0) is not overflow.
- **Priority in the same cycle:** `clear` > `pause` > tick. A tick coinciding with `pause` produces no `cnt_en`.
- **Scan**
  - Free-running in all states, including IDLE and HOLD, so the display is always live.
  - Divider 0..SCAN_DIV-1; `seg_sel` advances on wrap: 0→1→2→0. Value 3 never appears.
- `cnt_en` and `cnt_load` are never high in the same cycle.

## Timing
- **Reset values:** `state`=IDLE, `cnt_en`=0, `cnt_load`=0, `cnt_load_val`=0, `cnt_up`=1, `cnt_step`=0, `seg_sel`=0, both dividers 0.
- **Outputs:** all registered; no combinational input→output path.
- **`start`:** sampled at edge E0 gives RUN from E0. First `cnt_en` is high in the cycle after edge E0+TICK_DIV, then every TICK_DIV cycles.
- **Tick to pulse:** `cnt_en`/`cnt_load` follow one cycle after the tick cycle.
- **`count` assumption:** `count` is stable ≥1 cycle after `cnt_en`. Guaranteed by TICK_DIV≥2.
- **`clear`:** sampled at E gives `cnt_load`=1 with value 0 after E, and IDLE after E. Any pending tick is discarded.
- **Reset mid-operation:** everything returns to reset values on the next edge. No pulse is emitted that cycle.
- **Resuming from PAUSE or HOLD:** restarts the prescaler. The first pulse comes a full TICK_DIV period later.

## Structure
- Package `count_sched_pkg`:
  - state encoding constants (IDLE/RUN/PAUSE/HOLD)
  - `NDIG`=3
  - `CNT_MAX`=8'd255
  - `CNT_W`=8
  - `STEP_W`=4
- Sub-module `pulse_div` (parameter `DIV`; inputs `clk`, `rst`, `clr`, `en`; output `tick`). Instantiated twice:
  - prescaler: `en`=RUN, `clr`=not RUN
  - scan divider: `en`=1, `clr`=0
- Top-level holds the FSM, the overflow comparator, the output registers and the `seg_sel` counter.

## Test plan
- **Basic count:** TICK_DIV=4. Reset, `start` 1 cycle, `up_down`=1, `step`=3, `count` modelled by bench. Expect `cnt_en` in the cycle after edge E0+4, then every 4 cycles, `cnt_step`=3, `cnt_up`=1, no `cnt_load`.
- **Saturate up:** `sat_mode`=1, `count`=250, `step`=9, up. Expect `cnt_load`=1 with `cnt_load_val`=255, `state`=HOLD, no `cnt_en`. Then flip `up_down`=0: expect RUN, next `cnt_en` TICK_DIV cycles later with `cnt_up`=0.
- **Wrap and boundaries:**
  - `sat_mode`=0, `count`=250, `step`=9: expect `cnt_en` only.
  - `sat_mode`=1, `count`=250, `step`=5, up: expect `cnt_en`.
  - `sat_mode`=1, `count`=4, `step`=5, down: expect load 0 and HOLD.
  - `sat_mode`=1, `count`=5, `step`=5, down: expect `cnt_en`.
- **Mid-period change:** change `step` 3→7 mid-period. Expect `cnt_step` to stay 3 until the next tick, then become 7.
- **Priority:**
  - `pause` on the tick cycle: expect no `cnt_en`, `state`=PAUSE.
  - `clear` together with `pause` in RUN: expect `cnt_load` with value 0 and IDLE.
  - `rst` mid-RUN: expect all outputs at reset values.
- **Scan:** SCAN_DIV=2 in IDLE. Expect `seg_sel` sequence 0,0,1,1,2,2,0,0. Expect `seg_sel` never 3 and unaffected by FSM state changes.
